// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache request arbiter: access codes,
// the queued request record and a saturating counter increment.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ACC_READ       = 2'd0,
        ACC_WRITE      = 2'd1,
        ACC_INVALIDATE = 2'd2,
        ACC_NOP        = 2'd3
    } access_t;

    typedef struct packed {
        access_t     acc;
        logic [31:0] addr;
    } req_t;

    localparam int          REQ_ADDR_W = 32;
    localparam logic [31:0] STAT_MAX   = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == STAT_MAX) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Per-requester synchronous FIFO of req_t entries. Pointers wrap at DEPTH;
// push while full and pop while empty are ignored.
module cache_req_fifo
    import cache_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output req_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_t             mem_q [DEPTH];
    req_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port between NUM_REQ requesters.
// Optional statistics counters are enabled with CACHE_ARB_STATS_EN.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [2*NUM_REQ-1:0]         req_type,
    input  logic [ADDR_W*NUM_REQ-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [1:0]                   cache_access_type,
    output logic [ADDR_W-1:0]            cache_hex_address,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [32*NUM_REQ-1:0]        stat_grant_cnt,
    output logic [31:0]                  stat_drop_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SUM_W = ID_W + 1;

    logic [NUM_REQ-1:0] full_s;
    logic [NUM_REQ-1:0] empty_s;
    logic [NUM_REQ-1:0] push_s;
    logic [NUM_REQ-1:0] pop_s;
    req_t               head_s      [NUM_REQ];
    req_t               push_data_s [NUM_REQ];

    logic               win_found_s;
    logic [ID_W-1:0]    win_idx_s;

    access_t            acc_type_q, acc_type_d;
    logic [ADDR_W-1:0]  acc_addr_q, acc_addr_d;
    logic               grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    // Ready reflects pre-pop occupancy, so a full FIFO never accepts while popped.
    assign req_ready = rst_n ? ~full_s : '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cache_req_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_s[g]),
            .push_data (push_data_s[g]),
            .pop       (pop_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .head      (head_s[g])
        );
    end

    // Decode requester inputs; NOP entries are accepted but never queued.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push_data_s[i].acc  = access_t'(req_type[2*i +: 2]);
            push_data_s[i].addr = REQ_ADDR_W'(req_addr[ADDR_W*i +: ADDR_W]);
            push_s[i]           = req_valid[i] && req_ready[i] &&
                                  (push_data_s[i].acc != ACC_NOP);
        end
    end

    // Round-robin pick: first non-empty FIFO starting at rr_ptr.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  cand;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end else begin
                sum = sum;
            end
            cand = sum[ID_W-1:0];
            if (!win_found_s && !empty_s[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Output and pointer next-state; the winner is popped on the same edge.
    always_comb begin
        pop_s         = '0;
        acc_type_d    = ACC_NOP;
        acc_addr_d    = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (win_found_s) begin
            pop_s[win_idx_s] = 1'b1;
            acc_type_d       = head_s[win_idx_s].acc;
            acc_addr_d       = ADDR_W'(head_s[win_idx_s].addr);
            grant_valid_d    = 1'b1;
            grant_id_d       = win_idx_s;
            if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx_s + ID_W'(1);
            end
        end else begin
            grant_id_d = grant_id_q;
            rr_ptr_d   = rr_ptr_q;
        end
    end

    // Registered cache-side outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_type_q    <= ACC_NOP;
            acc_addr_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            acc_type_q    <= acc_type_d;
            acc_addr_q    <= acc_addr_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign cache_access_type = acc_type_q;
    assign cache_hex_address = acc_addr_q;
    assign grant_valid       = grant_valid_q;
    assign grant_id          = grant_id_q;

`ifdef CACHE_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Saturating per-requester grant counts and accepted-NOP count.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_found_s && (win_idx_s == ID_W'(i))) begin
                grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
            end else begin
                grant_cnt_d[i] = grant_cnt_q[i];
            end
            if (req_valid[i] && req_ready[i] && (req_type[2*i +: 2] == 2'd3)) begin
                drop_cnt_d = sat_inc(drop_cnt_d);
            end else begin
                drop_cnt_d = drop_cnt_d;
            end
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= 32'd0;
            end
            drop_cnt_q <= 32'd0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grant_cnt[32*g +: 32] = grant_cnt_q[g];
    end
    assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: hand-derived vector table plus a queue-based
// reference scoreboard checked every cycle.
module tb_cache_req_arbiter;
    import cache_arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [7:0]   req_type;
    logic [127:0] req_addr;
    logic [3:0]   req_ready;
    logic [1:0]   cache_access_type;
    logic [31:0]  cache_hex_address;
    logic         grant_valid;
    logic [1:0]   grant_id;
`ifdef CACHE_ARB_STATS_EN
    logic [127:0] stat_grant_cnt;
    logic [31:0]  stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    cache_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_type          (req_type),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .cache_access_type (cache_access_type),
        .cache_hex_address (cache_hex_address),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id)
`ifdef CACHE_ARB_STATS_EN
        ,
        .stat_grant_cnt    (stat_grant_cnt),
        .stat_drop_cnt     (stat_drop_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] a;
    } ent_t;

    typedef struct {
        logic         r;
        logic [3:0]   v;
        logic [7:0]   t;
        logic [127:0] a;
        logic [3:0]   x_rdy;
        logic [1:0]   x_type;
        logic [31:0]  x_addr;
        logic         x_gv;
        logic [1:0]   x_id;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model: per-requester queues are the scoreboard
    ent_t       mq [N][$];
    int         mrr;
    logic [1:0] e_type;
    logic [31:0] e_addr;
    logic       e_gv;
    logic [1:0] e_id;
    int         m_stat_g [N];
    int         m_drop;
    int         dut_g [N];
    bit         saw_lo [N];
    bit         saw_hi [N];
    bit         stream_on = 1'b0;
    vec_t       vt [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic void add(input logic r, input logic [3:0] v, input logic [7:0] t,
                                input logic [127:0] a, input logic [3:0] x_rdy,
                                input logic [1:0] x_type, input logic [31:0] x_addr,
                                input logic x_gv, input logic [1:0] x_id);
        vt.push_back('{r, v, t, a, x_rdy, x_type, x_addr, x_gv, x_id});
    endfunction

    task automatic cycle(input logic r, input logic [3:0] v, input logic [7:0] t,
                         input logic [127:0] a, output logic [3:0] pre_rdy);
        logic [3:0] rdy;
        int         w;
        int         idx;
        ent_t       e;
        rst_n = r; req_valid = v; req_type = t; req_addr = a;
        #1;
        for (int i = 0; i < N; i++) rdy[i] = r && (mq[i].size() < 4);
        check("req_ready", {28'd0, req_ready}, {28'd0, rdy});
        pre_rdy = req_ready;
        if (stream_on) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) saw_hi[i] = 1'b1;
                else saw_lo[i] = 1'b1;
            end
        end
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                m_stat_g[i] = 0;
            end
            mrr = 0; m_drop = 0;
            e_type = 2'd3; e_addr = 32'd0; e_gv = 1'b0; e_id = 2'd0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mrr + k) % N;
                if (w < 0 && mq[idx].size() > 0) w = idx;
            end
            if (w >= 0) begin
                e = mq[w].pop_front();
                e_type = e.t; e_addr = e.a; e_gv = 1'b1; e_id = 2'(w);
                mrr = (w + 1) % N;
                m_stat_g[w]++;
            end else begin
                e_type = 2'd3; e_addr = 32'd0; e_gv = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    if (t[2*i +: 2] != 2'd3) begin
                        e.t = t[2*i +: 2]; e.a = a[32*i +: 32];
                        mq[i].push_back(e);
                    end else begin
                        m_drop++;
                    end
                end
            end
        end
        #1;
        check("sb_type", {30'd0, cache_access_type}, {30'd0, e_type});
        check("sb_addr", cache_hex_address, e_addr);
        check("sb_grant_valid", {31'd0, grant_valid}, {31'd0, e_gv});
        check("sb_grant_id", {30'd0, grant_id}, {30'd0, e_id});
        if (stream_on && grant_valid) dut_g[grant_id]++;
`ifdef CACHE_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check($sformatf("sb_stat_grant%0d", i), stat_grant_cnt[32*i +: 32], 32'(m_stat_g[i]));
        check("sb_stat_drop", stat_drop_cnt, 32'(m_drop));
`endif
    endtask

    initial begin
        logic [3:0] pr;
        logic [7:0] tt;
        logic [127:0] aa;
        rst_n = 1'b0; req_valid = 4'h0; req_type = 8'h00; req_addr = 128'd0;

        // r  v      t      addrs                                             rdy    type   addr          gv    id
        add(1'b0, 4'hF, 8'h00, 128'd0,                                        4'h0, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b0, 4'hF, 8'h00, 128'd0,                                        4'h0, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b1, 4'h1, 8'h00, pack4(32'h0, 32'h0, 32'h0, 32'h0000_1040),     4'hF, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd0, 32'h0000_1040, 1'b1, 2'd0);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b0, 4'h0, 8'h00, 128'd0,                                        4'h0, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b1, 4'hF, 8'h55, pack4(32'h400, 32'h300, 32'h200, 32'h100),     4'hF, 2'd3, 32'h0,        1'b0, 2'd0);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h100,      1'b1, 2'd0);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h200,      1'b1, 2'd1);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h300,      1'b1, 2'd2);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h400,      1'b1, 2'd3);
        add(1'b1, 4'h6, 8'h55, pack4(32'h0, 32'h600, 32'h500, 32'h0),         4'hF, 2'd3, 32'h0,        1'b0, 2'd3);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h500,      1'b1, 2'd1);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd1, 32'h600,      1'b1, 2'd2);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd3, 32'h0,        1'b0, 2'd2);
        add(1'b1, 4'h2, 8'h0C, pack4(32'h0, 32'h0, 32'h9999, 32'h0),          4'hF, 2'd3, 32'h0,        1'b0, 2'd2);
        add(1'b1, 4'h2, 8'h08, pack4(32'h0, 32'h0, 32'h0000_2000, 32'h0),     4'hF, 2'd3, 32'h0,        1'b0, 2'd2);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd2, 32'h0000_2000, 1'b1, 2'd1);
        add(1'b1, 4'h0, 8'h00, 128'd0,                                        4'hF, 2'd3, 32'h0,        1'b0, 2'd1);

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].r, vt[i].v, vt[i].t, vt[i].a, pr);
            check($sformatf("row%0d_ready", i), {28'd0, pr}, {28'd0, vt[i].x_rdy});
            check($sformatf("row%0d_type", i), {30'd0, cache_access_type}, {30'd0, vt[i].x_type});
            check($sformatf("row%0d_addr", i), cache_hex_address, vt[i].x_addr);
            check($sformatf("row%0d_gv", i), {31'd0, grant_valid}, {31'd0, vt[i].x_gv});
            check($sformatf("row%0d_id", i), {30'd0, grant_id}, {30'd0, vt[i].x_id});
        end
`ifdef CACHE_ARB_STATS_EN
        check("drop_cnt_after_nop", stat_drop_cnt, 32'd1);
`endif

        // continuous streaming from all requesters: FIFOs saturate
        cycle(1'b0, 4'h0, 8'h00, 128'd0, pr);
        for (int i = 0; i < N; i++) begin
            dut_g[i] = 0; saw_lo[i] = 1'b0; saw_hi[i] = 1'b0;
        end
        stream_on = 1'b1;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                tt[2*i +: 2] = 2'($urandom_range(0, 2));
                aa[32*i +: 32] = $urandom;
            end
            cycle(1'b1, 4'hF, tt, aa, pr);
        end
        stream_on = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("fair_share%0d", i), {31'd0, (dut_g[i] >= 49 && dut_g[i] <= 50)}, 32'd1);
            check($sformatf("ready_low_seen%0d", i), {31'd0, saw_lo[i]}, 32'd1);
            check($sformatf("ready_high_seen%0d", i), {31'd0, saw_hi[i]}, 32'd1);
        end
        for (int c = 0; c < 20; c++) cycle(1'b1, 4'h0, 8'h00, 128'd0, pr);

        // ten uncontended grants to requester 3
        cycle(1'b0, 4'h0, 8'h00, 128'd0, pr);
        for (int c = 0; c < 10; c++)
            cycle(1'b1, 4'h8, 8'h00, pack4(32'h3000 + 32'(c), 32'h0, 32'h0, 32'h0), pr);
        for (int c = 0; c < 3; c++) cycle(1'b1, 4'h0, 8'h00, 128'd0, pr);
`ifdef CACHE_ARB_STATS_EN
        check("stat_req3_ten", stat_grant_cnt[127:96], 32'd10);
        check("stat_req0_zero", stat_grant_cnt[31:0], 32'd0);
        check("stat_req1_zero", stat_grant_cnt[63:32], 32'd0);
        check("stat_req2_zero", stat_grant_cnt[95:64], 32'd0);
`endif

        // reset in the middle of a stream drops everything queued
        for (int c = 0; c < 3; c++)
            cycle(1'b1, 4'hF, 8'h00, pack4(32'hA3, 32'hA2, 32'hA1, 32'hA0), pr);
        cycle(1'b0, 4'hF, 8'h00, 128'd0, pr);
`ifdef CACHE_ARB_STATS_EN
        check("stat_cleared3", stat_grant_cnt[127:96], 32'd0);
        check("stat_drop_cleared", stat_drop_cnt, 32'd0);
`endif
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 4'h0, 8'h00, 128'd0, pr);
            check("post_reset_idle", {31'd0, grant_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
